// File: rtl/lohi_requester_pkg.sv
// Shared HI/LO unit definitions: op codes, write-option codes and requester state encodings.
package lohi_requester_pkg;

  localparam int LOHI_OP_WIDTH        = 3;
  localparam int LOHI_WRITE_OPT_WIDTH = 2;

  typedef enum logic [LOHI_OP_WIDTH-1:0] {
    LOHI_OP_NONE  = 3'd0,
    LOHI_OP_MULT  = 3'd1,
    LOHI_OP_MULTU = 3'd2,
    LOHI_OP_MFHI  = 3'd3,
    LOHI_OP_MFLO  = 3'd4,
    LOHI_OP_MTHI  = 3'd5,
    LOHI_OP_MTLO  = 3'd6
  } lohi_op_e;

  typedef enum logic [LOHI_WRITE_OPT_WIDTH-1:0] {
    LOHI_WRITE_NONE = 2'd0,
    LOHI_WRITE_LO   = 2'd1,
    LOHI_WRITE_HI   = 2'd2
  } lohi_write_e;

  typedef enum logic [2:0] {
    LOHI_STATE_IDLE   = 3'd0,
    LOHI_STATE_START  = 3'd1,
    LOHI_STATE_WAIT   = 3'd2,
    LOHI_STATE_FIX_LO = 3'd3,
    LOHI_STATE_FIX_HI = 3'd4
  } lohi_state_e;

endpackage

// File: rtl/lohi_requester_if.sv
// Requester <-> HI/LO multiplier connection; master is the requester, slave is the multiplier.
interface lohi_requester_if;
  import lohi_requester_pkg::*;

  logic                            mul_start;
  logic [31:0]                     mul_opr1;
  logic [31:0]                     mul_opr2;
  logic [LOHI_WRITE_OPT_WIDTH-1:0] mul_write_opt;
  logic [31:0]                     mul_write_data;
  logic [63:0]                     mul_result;
  logic                            mul_ready;

  modport master (
    output mul_start, mul_opr1, mul_opr2, mul_write_opt, mul_write_data,
    input  mul_result, mul_ready
  );

  modport slave (
    input  mul_start, mul_opr1, mul_opr2, mul_write_opt, mul_write_data,
    output mul_result, mul_ready
  );

endinterface

// File: rtl/lohi_sign_fix.sv
// Combinational abs/negate helper for signed MULT; present only when LOHI_SIGNED_MULT_EN is defined.
`ifdef LOHI_SIGNED_MULT_EN
module lohi_sign_fix (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [63:0] p,
  output logic [31:0] abs_a,
  output logic [31:0] abs_b,
  output logic [63:0] neg_p
);

  assign abs_a = a[31] ? (~a + 32'd1) : a;
  assign abs_b = b[31] ? (~b + 32'd1) : b;
  assign neg_p = ~p + 64'd1;

endmodule
`endif

// File: rtl/lohi_requester.sv
// EX-stage initiator for the HI/LO multiplier; stalls HI/LO ops until the unit can serve them.
// Signed MULT sign fixup is built in when LOHI_SIGNED_MULT_EN is defined.
//   state  | meaning
//   IDLE   | no multiply in flight, ops accepted when mul_ready
//   START  | mul_start high for this one cycle
//   WAIT   | multiply in flight, ready ignored for WAIT_GUARD cycles
//   FIX_LO | write negated product low word (signed build only)
//   FIX_HI | write negated product high word (signed build only)
module lohi_requester
  import lohi_requester_pkg::*;
#(
  parameter int WAIT_GUARD = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     op_valid,
  input  logic [LOHI_OP_WIDTH-1:0] op,
  input  logic [31:0]              rs_data,
  input  logic [31:0]              rt_data,
  output logic [31:0]              rd_data,
  output logic                     stall,
  lohi_requester_if.master         mul
);

  localparam int GW = (WAIT_GUARD > 0) ? $clog2(WAIT_GUARD + 1) : 1;

  lohi_state_e   state;
  logic [GW-1:0] guard_cnt;
  logic          op_req, is_mul, wait_done, free, accept, launch;
  logic [31:0]   opr1_nxt, opr2_nxt;

`ifdef LOHI_SIGNED_MULT_EN
  logic        neg;
  logic        neg_nxt;
  logic [31:0] abs_rs, abs_rt;
  logic [63:0] neg_result, fix_val;

  lohi_sign_fix u_sign_fix (
    .a     (rs_data),
    .b     (rt_data),
    .p     (mul.mul_result),
    .abs_a (abs_rs),
    .abs_b (abs_rt),
    .neg_p (neg_result)
  );

  assign neg_nxt  = (op == LOHI_OP_MULT) & (rs_data[31] ^ rt_data[31]);
  assign opr1_nxt = (op == LOHI_OP_MULT) ? abs_rs : rs_data;
  assign opr2_nxt = (op == LOHI_OP_MULT) ? abs_rt : rt_data;
  assign free     = (state == LOHI_STATE_IDLE) | (wait_done & ~neg);
`else
  assign opr1_nxt = rs_data;
  assign opr2_nxt = rt_data;
  assign free     = (state == LOHI_STATE_IDLE) | wait_done;
`endif

  // The completion cycle of WAIT already behaves as idle so a dependent op is not delayed a cycle.
  assign wait_done = (state == LOHI_STATE_WAIT) & (guard_cnt == '0) & mul.mul_ready;
  assign op_req    = op_valid & (op != LOHI_OP_NONE);
  assign is_mul    = (op == LOHI_OP_MULT) | (op == LOHI_OP_MULTU);
  assign accept    = op_req & free & mul.mul_ready;
  assign launch    = accept & is_mul;
  assign stall     = ~rst & op_req & ~accept;

  always_comb begin
    rd_data = '0;
    if (accept && op == LOHI_OP_MFHI)      rd_data = mul.mul_result[63:32];
    else if (accept && op == LOHI_OP_MFLO) rd_data = mul.mul_result[31:0];
  end

  always_comb begin
    mul.mul_write_opt  = LOHI_WRITE_NONE;
    mul.mul_write_data = '0;
    if (!rst) begin
      if (accept && op == LOHI_OP_MTHI) begin
        mul.mul_write_opt  = LOHI_WRITE_HI;
        mul.mul_write_data = rs_data;
      end else if (accept && op == LOHI_OP_MTLO) begin
        mul.mul_write_opt  = LOHI_WRITE_LO;
        mul.mul_write_data = rs_data;
      end
`ifdef LOHI_SIGNED_MULT_EN
      else if (state == LOHI_STATE_FIX_LO) begin
        mul.mul_write_opt  = LOHI_WRITE_LO;
        mul.mul_write_data = fix_val[31:0];
      end else if (state == LOHI_STATE_FIX_HI) begin
        mul.mul_write_opt  = LOHI_WRITE_HI;
        mul.mul_write_data = fix_val[63:32];
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= LOHI_STATE_IDLE;
      guard_cnt     <= '0;
      mul.mul_start <= 1'b0;
      mul.mul_opr1  <= '0;
      mul.mul_opr2  <= '0;
`ifdef LOHI_SIGNED_MULT_EN
      neg           <= 1'b0;
      fix_val       <= '0;
`endif
    end else begin
      mul.mul_start <= 1'b0;
      if (launch) begin
        mul.mul_opr1  <= opr1_nxt;
        mul.mul_opr2  <= opr2_nxt;
        mul.mul_start <= 1'b1;
        state         <= LOHI_STATE_START;
`ifdef LOHI_SIGNED_MULT_EN
        neg           <= neg_nxt;
`endif
      end else begin
        case (state)
          LOHI_STATE_IDLE: state <= LOHI_STATE_IDLE;
          LOHI_STATE_START: begin
            guard_cnt <= GW'(WAIT_GUARD);
            state     <= LOHI_STATE_WAIT;
          end
          LOHI_STATE_WAIT: begin
            if (guard_cnt != '0) begin
              guard_cnt <= guard_cnt - GW'(1);
            end else if (mul.mul_ready) begin
`ifdef LOHI_SIGNED_MULT_EN
              if (neg) begin
                fix_val <= neg_result;
                state   <= LOHI_STATE_FIX_LO;
              end else begin
                state   <= LOHI_STATE_IDLE;
              end
`else
              state <= LOHI_STATE_IDLE;
`endif
            end
          end
`ifdef LOHI_SIGNED_MULT_EN
          LOHI_STATE_FIX_LO: state <= LOHI_STATE_FIX_HI;
          LOHI_STATE_FIX_HI: begin
            neg   <= 1'b0;
            state <= LOHI_STATE_IDLE;
          end
`endif
          default: state <= LOHI_STATE_IDLE;
        endcase
      end
    end
  end

endmodule
